// File: rtl/display_scan_ctrl.sv
// Four-digit seven-segment scan controller: rotates the anodes, snapshots BCD digits
// once per frame so the display never tears, and blanks the adjust field while blinking.
module display_scan_ctrl #(
  parameter int SCAN_DIV   = 100000,
  parameter int BLINK_DIV  = 25000000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] min_tens,
  input  logic [3:0] min_ones,
  input  logic [3:0] sec_tens,
  input  logic [3:0] sec_ones,
  input  logic       blink_enable,
  input  logic       sel_minutes,
  input  logic       sel_seconds,
  output logic [3:0] an,
  output logic [3:0] digit,
  output logic       dp,
  output logic       blank,
  output logic       frame_start
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [3:0] AN_OFF = ACTIVE_LOW ? 4'b1111 : 4'b0000;

  logic [SW-1:0]     scan_cnt, scan_cnt_nx;
  logic [1:0]        idx, idx_nx;
  logic [3:0][3:0]   shadow, shadow_nx;
  logic              load_pend, load_pend_nx;
  logic [BW-1:0]     blink_cnt, blink_cnt_nx;
  logic              blink_phase, blink_phase_nx;

  logic              scan_wrap;
  logic              frame_wrap;
  logic [3:0]        an_nx, an_on, onehot;
  logic [3:0]        digit_nx;
  logic              dp_nx, blank_nx, frame_start_nx, field_sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt    <= '0;
      idx         <= 2'd0;
      shadow      <= '0;
      load_pend   <= 1'b1;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      scan_cnt    <= scan_cnt_nx;
      idx         <= idx_nx;
      shadow      <= shadow_nx;
      load_pend   <= load_pend_nx;
      blink_cnt   <= blink_cnt_nx;
      blink_phase <= blink_phase_nx;
    end
  end

  always_comb begin
    scan_wrap   = (scan_cnt == SW'(SCAN_DIV - 1));
    frame_wrap  = scan_wrap && (idx == 2'd3);
    scan_cnt_nx = scan_wrap ? '0 : scan_cnt + SW'(1);
    idx_nx      = scan_wrap ? idx + 2'd1 : idx;
    // shadow is indexed by idx: [0]=sec_ones ... [3]=min_tens
    shadow_nx   = (frame_wrap || load_pend) ?
                  {min_tens, min_ones, sec_tens, sec_ones} : shadow;
    load_pend_nx = 1'b0;

    blink_cnt_nx   = '0;
    blink_phase_nx = 1'b0;
    if (blink_enable) begin
      if (blink_cnt == BW'(BLINK_DIV - 1)) begin
        blink_cnt_nx   = '0;
        blink_phase_nx = ~blink_phase;
      end else begin
        blink_cnt_nx   = blink_cnt + BW'(1);
        blink_phase_nx = blink_phase;
      end
    end
  end

  always_comb begin
    field_sel      = idx[1] ? sel_minutes : sel_seconds;
    blank_nx       = blink_enable & blink_phase & field_sel;
    onehot         = 4'b0001 << idx;
    an_on          = blank_nx ? 4'b0000 : onehot;
    an_nx          = ACTIVE_LOW ? ~an_on : an_on;
    dp_nx          = ((idx == 2'd2) && !blank_nx) ^ ACTIVE_LOW;
    digit_nx       = shadow[idx];
    // scan_cnt==0 at idx 0 also occurs right after reset; load_pend masks that frame
    frame_start_nx = (scan_cnt == '0) && (idx == 2'd0) && !load_pend;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      an          <= AN_OFF;
      digit       <= 4'd0;
      dp          <= ACTIVE_LOW;
      blank       <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      an          <= an_nx;
      digit       <= digit_nx;
      dp          <= dp_nx;
      blank       <= blank_nx;
      frame_start <= frame_start_nx;
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl with SCAN_DIV=4, BLINK_DIV=8, active-low pins: directed
// table, hand-written corner sequences and a randomized run against a time-based model.
module tb_display_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] min_tens = '0, min_ones = '0, sec_tens = '0, sec_ones = '0;
  logic       blink_enable = 1'b0, sel_minutes = 1'b0, sel_seconds = 1'b0;
  logic [3:0] an, digit;
  logic       dp, blank, frame_start;

  int checks = 0;
  int errors = 0;

  // model: cycles since reset release, consecutive enabled cycles, snapshot
  int         m_k   = 0;
  int         m_run = 0;
  logic [3:0] m_shadow [4];

  typedef struct {
    logic        r;
    logic [15:0] d;
    logic [3:0]  an;
    logic [3:0]  digit;
    logic        dp;
    logic        blank;
    logic        fs;
  } vec_t;
  vec_t tbl [21];

  display_scan_ctrl #(.SCAN_DIV(4), .BLINK_DIV(8), .ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst(rst),
    .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
    .blink_enable(blink_enable), .sel_minutes(sel_minutes), .sel_seconds(sel_seconds),
    .an(an), .digit(digit), .dp(dp), .blank(blank), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // d = {min_tens, min_ones, sec_tens, sec_ones}
  task automatic step(input logic r, input logic [15:0] d, input logic en,
                      input logic sm, input logic ss);
    logic [3:0] e_an, e_digit, bit_on;
    logic       e_dp, e_blank, e_fs, hidden;
    int         pos, sel_idx, phase;
    @(negedge clk);
    rst = r;
    {min_tens, min_ones, sec_tens, sec_ones} = d;
    blink_enable = en; sel_minutes = sm; sel_seconds = ss;
    if (r) begin
      e_an = 4'hF; e_digit = 4'd0; e_dp = 1'b1; e_blank = 1'b1; e_fs = 1'b0;
      m_k = 0; m_run = 0;
      for (int i = 0; i < 4; i++) m_shadow[i] = 4'd0;
    end else begin
      pos     = m_k % 16;
      sel_idx = pos / 4;
      phase   = (m_run / 8) % 2;
      hidden  = en && (phase == 1) && ((sel_idx >= 2) ? sm : ss);
      bit_on  = 4'b0001 << sel_idx;
      e_blank = hidden;
      e_digit = m_shadow[sel_idx];
      e_an    = hidden ? 4'hF : ~bit_on;
      e_dp    = !((sel_idx == 2) && !hidden);
      e_fs    = (m_k > 0) && (pos == 0);
      if (m_k == 0 || pos == 15) begin
        m_shadow[0] = d[3:0]; m_shadow[1] = d[7:4];
        m_shadow[2] = d[11:8]; m_shadow[3] = d[15:12];
      end
      m_k++;
      m_run = en ? m_run + 1 : 0;
    end
    @(posedge clk);
    #1;
    check("an", an, e_an);
    check("digit", digit, e_digit);
    check("dp", dp, e_dp);
    check("blank", blank, e_blank);
    check("frame_start", frame_start, e_fs);
  endtask

  function automatic vec_t mk(input logic r, input logic [3:0] a, input logic [3:0] dg,
                              input logic p, input logic b, input logic f);
    vec_t v;
    v.r = r; v.d = 16'h1234; v.an = a; v.digit = dg; v.dp = p; v.blank = b; v.fs = f;
    return v;
  endfunction

  initial begin
    logic [15:0] d;
    logic        en, sm, ss;
    int          cnt;

    tbl[0]  = mk(1, 4'hF, 0, 1, 1, 0);
    tbl[1]  = mk(1, 4'hF, 0, 1, 1, 0);
    tbl[2]  = mk(1, 4'hF, 0, 1, 1, 0);
    tbl[3]  = mk(0, 4'hE, 0, 1, 0, 0);
    tbl[4]  = mk(0, 4'hE, 4, 1, 0, 0);
    tbl[5]  = mk(0, 4'hE, 4, 1, 0, 0);
    tbl[6]  = mk(0, 4'hE, 4, 1, 0, 0);
    tbl[7]  = mk(0, 4'hD, 3, 1, 0, 0);
    tbl[8]  = mk(0, 4'hD, 3, 1, 0, 0);
    tbl[9]  = mk(0, 4'hD, 3, 1, 0, 0);
    tbl[10] = mk(0, 4'hD, 3, 1, 0, 0);
    tbl[11] = mk(0, 4'hB, 2, 0, 0, 0);
    tbl[12] = mk(0, 4'hB, 2, 0, 0, 0);
    tbl[13] = mk(0, 4'hB, 2, 0, 0, 0);
    tbl[14] = mk(0, 4'hB, 2, 0, 0, 0);
    tbl[15] = mk(0, 4'h7, 1, 1, 0, 0);
    tbl[16] = mk(0, 4'h7, 1, 1, 0, 0);
    tbl[17] = mk(0, 4'h7, 1, 1, 0, 0);
    tbl[18] = mk(0, 4'h7, 1, 1, 0, 0);
    tbl[19] = mk(0, 4'hE, 4, 1, 0, 1);
    tbl[20] = mk(0, 4'hE, 4, 1, 0, 0);

    // reset and scan order
    for (int i = 0; i < 21; i++) begin
      step(tbl[i].r, tbl[i].d, 1'b0, 1'b0, 1'b0);
      check("tbl_an", an, tbl[i].an);
      check("tbl_digit", digit, tbl[i].digit);
      check("tbl_dp", dp, tbl[i].dp);
      check("tbl_blank", blank, tbl[i].blank);
      check("tbl_frame_start", frame_start, tbl[i].fs);
    end

    // tear-free: change sec_ones while idx 2 is on the pins
    while (m_k % 16 != 9) step(0, 16'h1234, 0, 0, 0);
    step(0, 16'h1239, 0, 0, 0);
    check("tear_hold", an, 4'hB);
    for (int i = 0; i < 6; i++) step(0, 16'h1239, 0, 0, 0);
    while (frame_start !== 1'b1 && m_k < 200) begin
      if (an == 4'hE) check("tear_old_digit", digit, 4'd4);
      step(0, 16'h1239, 0, 0, 0);
    end
    check("tear_new_frame", frame_start, 1'b1);
    check("tear_new_digit", digit, 4'd9);

    // minutes blink from cycle 0 after reset
    step(1, 16'h1234, 0, 0, 0);
    cnt = 0;
    for (int j = 0; j < 8; j++) begin
      step(0, 16'h1234, 1, 1, 0);
      cnt += int'(blank);
    end
    check("blink_first_visible", cnt, 0);
    cnt = 0;
    for (int j = 8; j < 16; j++) begin
      step(0, 16'h1234, 1, 1, 0);
      cnt += int'(blank);
    end
    check("blink_hidden_count", cnt, 8);
    for (int j = 16; j < 26; j++) step(0, 16'h1234, 1, 1, 0);
    check("blink_hidden_again", blank, 1'b1);
    // cancel in hidden phase, then re-assert
    step(0, 16'h1234, 0, 1, 0);
    check("blink_cancel", blank, 1'b0);
    cnt = 0;
    for (int j = 0; j < 8; j++) begin
      step(0, 16'h1234, 1, 1, 0);
      cnt += int'(blank);
    end
    check("blink_reassert_visible", cnt, 0);
    for (int j = 0; j < 12; j++) step(0, 16'h1234, 1, 1, 0);

    // mid-frame reset while an=1011
    while (m_k % 16 != 9) step(0, 16'h1234, 0, 0, 0);
    step(1, 16'h5678, 0, 0, 0);
    check("midrst_an", an, 4'hF);
    step(0, 16'h5678, 0, 0, 0);
    check("midrst_restart_an", an, 4'hE);
    check("midrst_no_fs", frame_start, 1'b0);
    step(0, 16'h5678, 0, 0, 0);
    check("midrst_reload", digit, 4'd8);
    for (int j = 0; j < 14; j++) step(0, 16'h5678, 0, 0, 0);

    // randomized run against the model
    d = 16'h0000; en = 0; sm = 0; ss = 0;
    for (int i = 0; i < 3000; i++) begin
      d = 16'($urandom);
      if ($urandom_range(0, 19) == 0) en = ~en;
      if ($urandom_range(0, 29) == 0) sm = ~sm;
      if ($urandom_range(0, 29) == 0) ss = ~ss;
      step(($urandom_range(0, 299) == 0), d, en, sm, ss);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
Time-multiplexed scan controller for the 4-digit seven-segment display of the MM:SS clock. It rotates the shared cathode bus across the four digit anodes and snapshots the BCD digits once per frame so the display never tears. It applies adjust-mode blinking to the selected field, using the blink/select outputs of the mode FSM. It drives the BCD-to-segment decoder and the board anode/dp pins.

Parameters:
SCAN_DIV, 100000, clk cycles each digit stays active (100 MHz -> 1 kHz per digit); must be >= 2
BLINK_DIV, 25000000, clk cycles per blink half-period (100 MHz -> 2 Hz toggle)
ACTIVE_LOW, 1, 1: an and dp are active-low; 0: active-high

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
min_tens  in  4  BCD minutes tens
min_ones  in  4  BCD minutes ones
sec_tens  in  4  BCD seconds tens
sec_ones  in  4  BCD seconds ones
blink_enable  in  1  adjust-mode blink request
sel_minutes  in  1  minutes field selected for adjust
sel_seconds  in  1  seconds field selected for adjust
an  out  4  digit anode enables (an[0]=sec_ones … an[3]=min_tens)
digit  out  4  BCD value to segment decoder
dp  out  1  decimal point (colon substitute after min_ones)
blank  out  1  1 = current digit suppressed
frame_start  out  1  one-cycle pulse, first output cycle of idx 0

Behaviour:
- One clock, synchronous active-high reset. All outputs are registered.
- State: scan_cnt (0..SCAN_DIV-1), idx (2 bits), shadow[4] (4 bits each), load_pend, blink_cnt (0..BLINK_DIV-1), blink_phase.
- Reset values: scan_cnt=0, idx=0, shadow=0, load_pend=1, blink_cnt=0, blink_phase=0. Outputs during reset: an=all off (4'b1111 if ACTIVE_LOW, else 0), digit=0, dp=off, blank=1, frame_start=0.
- Scan: scan_cnt increments each cycle. At SCAN_DIV-1 it wraps to 0 and idx advances 0->1->2->3->0.
- Snapshot: shadow loads all four inputs on the edge where idx wraps 3->0, or on the edge where load_pend=1 (first cycle after reset). load_pend clears after that edge. Inputs are never displayed directly.
- Digit map: idx0=sec_ones, idx1=sec_tens, idx2=min_ones, idx3=min_tens. Values > 9 pass through unchanged.
- Output latency is exactly 1 cycle. The outputs at cycle n+1 reflect idx, shadow, blink_phase, blink_enable and sel_* at cycle n.
- an: one-hot on bit idx, polarity per ACTIVE_LOW. Forced all-off when blank=1.
- digit: shadow[idx]. It is driven even when blanked.
- dp: active only when idx=2 and not blanked.
- Blink counter:
  - while blink_enable=0: blink_cnt=0, blink_phase=0.
  - while blink_enable=1: blink_cnt counts and wraps at BLINK_DIV-1, toggling blink_phase. The phase after enable is therefore visible for BLINK_DIV cycles first.
- blank = blink_enable & blink_phase & ((sel_minutes & idx∈{2,3}) | (sel_seconds & idx∈{0,1})).
  - sel_minutes=sel_seconds=1 blanks all digits in the hidden phase.
  - sel_*=0 with blink_enable=1 blanks nothing.
- frame_start: high for the single cycle in which outputs first show idx 0 after an idx wrap. Not asserted for the first post-reset frame.
- Reset mid-operation: takes effect on the next edge regardless of scan/blink position. The scan restarts at idx 0 and shadow is reloaded on the first post-reset cycle.
- Simultaneous events:
  - snapshot at wrap and blink toggle on the same edge are independent.
  - a blink_enable fall on a phase-toggle edge leaves phase=0.
- Expected size: ~150 RTL lines.

Test Plan:
1. Reset, with SCAN_DIV=4, BLINK_DIV=8 and inputs 1,2,3,4: hold rst 3 cycles -> an=1111, blank=1, digit=0, dp=1 (off), frame_start=0. Release -> second cycle after release shows an=1110, digit=4.
2. Scan order, same params, min=12, sec=34 -> an/digit sequence 1110/4, 1101/3, 1011/2 (dp=0), 0111/1, each held 4 cycles, repeating. frame_start pulses every 16 cycles coincident with an=1110.
3. Tear-free update: change sec_ones 4->9 while an=1011 -> digit under an=1110 stays 4 for the rest of the frame and shows 9 from the next frame_start.
4. Minutes blink: blink_enable=1, sel_minutes=1 from cycle 0 -> cycles 1-8 all digits visible. Cycles 9-16: when idx∈{2,3}, an=1111 and blank=1. Seconds digits stay unaffected throughout, alternating every 8 cycles.
5. Blink cancel: drop blink_enable during the hidden phase -> blank=0 one cycle later. Re-assert -> 8 visible cycles before the first blanking.
6. Mid-frame reset: assert rst for 1 cycle while an=1011 -> next cycle shows reset outputs. Scan resumes at an=1110 with shadow reloaded from current inputs, and no frame_start on that restart.
